// File: rtl/instruction_fetch.sv
// instruction_fetch
// Read-side master for program_memory. It walks the PC over the ROM, assembles
// 1- or 2-byte instructions and hands each one to execute through a
// valid/ready handshake. Branch redirects from execute override everything.
//
// The ROM is combinational (data_bus = rom[address_bus]), so the byte at the
// current PC can be captured on the same edge that advances the PC.
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target
);

  // S_OP    : waiting to capture the opcode byte at pc
  // S_IMM   : opcode captured, waiting to capture the operand byte at pc
  // S_VALID : a complete instruction is presented to execute
  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_IMM   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // PC increment constant sized to the address width; the adder wraps
  // naturally modulo 2**ADDR_W, so an opcode at the top address takes its
  // operand from address zero.
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  // Instruction length encodings presented on instr_len.
  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_ONE  = 2'd1;
  localparam logic [1:0] LEN_TWO  = 2'd2;

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] pc_reg,       pc_next;
  logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
  logic [DATA_W-1:0] opcode_reg,   opcode_next;
  logic [DATA_W-1:0] operand_reg,  operand_next;
  logic [1:0]        len_reg,      len_next;

  // Opcode classes that carry an immediate/target byte:
  //   LD imm  : 1000_00xx
  //   CMP imm : 1000_11xx
  //   BRA/BHI/BEQ : 101x_xxxx
  // Every other opcode is a single byte.
  function automatic logic is_two_byte(input logic [DATA_W-1:0] b);
    logic two;
    two = 1'b0;
    if (b[7:2] == 6'b100000) two = 1'b1;
    if (b[7:2] == 6'b100011) two = 1'b1;
    if (b[7:5] == 3'b101)    two = 1'b1;
    return two;
  endfunction

  // Next-state and datapath update; a redirect wins over every other action
  // and discards whatever was partially fetched or still waiting on ready.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_pc_next = instr_pc_reg;
    opcode_next   = opcode_reg;
    operand_next  = operand_reg;
    len_next      = len_reg;

    if (branch_valid) begin
      // The handshake of an instruction presented in this same cycle still
      // completes on the execute side; here we only restart the fetch.
      state_next = S_OP;
      pc_next    = branch_target;
    end else begin
      unique case (state_reg)
        S_OP: begin
          if (fetch_en) begin
            opcode_next   = data_bus;
            instr_pc_next = pc_reg;
            pc_next       = pc_reg + PC_ONE;
            if (is_two_byte(data_bus)) begin
              state_next = S_IMM;
            end else begin
              operand_next = '0;
              len_next     = LEN_ONE;
              state_next   = S_VALID;
            end
          end
        end

        S_IMM: begin
          if (fetch_en) begin
            operand_next = data_bus;
            pc_next      = pc_reg + PC_ONE;
            len_next     = LEN_TWO;
            state_next   = S_VALID;
          end
        end

        S_VALID: begin
          // The handshake is deliberately not gated by fetch_en: execute can
          // always drain the instruction that is already assembled.
          if (instr_ready) begin
            state_next = S_OP;
          end
        end

        default: begin
          state_next = S_OP;
        end
      endcase
    end
  end

  // State and datapath registers; reset clears everything at once so that a
  // reset mid-instruction leaves no stale partial fetch behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_OP;
      pc_reg       <= RESET_PC;
      instr_pc_reg <= '0;
      opcode_reg   <= '0;
      operand_reg  <= '0;
      len_reg      <= LEN_NONE;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_pc_reg <= instr_pc_next;
      opcode_reg   <= opcode_next;
      operand_reg  <= operand_next;
      len_reg      <= len_next;
    end
  end

  // The ROM address is the PC register itself, so it is glitch-free and
  // already settled at the start of every cycle.
  assign address_bus   = pc_reg;
  assign instr_valid   = (state_reg == S_VALID);
  assign instr_opcode  = opcode_reg;
  assign instr_operand = operand_reg;
  assign instr_len     = len_reg;
  assign instr_pc      = instr_pc_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// Directed scenarios followed by a randomized run checked against a
// transaction-level model: the model only tracks "address of the next
// instruction execute should receive" and decodes it straight from the ROM.
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic       clk;
  logic       reset;
  logic       fetch_en;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       branch_valid;
  logic [7:0] branch_target;

  logic [7:0] rom [256];

  int errors = 0;
  int checks = 0;

  instruction_fetch #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .address_bus  (address_bus),
    .data_bus     (data_bus),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .branch_valid (branch_valid),
    .branch_target(branch_target)
  );

  // Combinational program memory.
  assign data_bus = rom[address_bus];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the presented instruction: valid, opcode, operand, len, pc.
  logic [26:0] obs;
  assign obs = {instr_valid, instr_opcode, instr_operand, instr_len, instr_pc};

  function automatic logic [26:0] mk(input logic [7:0] op, input logic [7:0] opd,
                                     input logic [1:0] len, input logic [7:0] pc);
    return {1'b1, op, opd, len, pc};
  endfunction

  // Reference length rule taken from the instruction set description.
  function automatic int ref_len(input logic [7:0] b);
    if (b[7:2] == 6'b100000) return 2;   // LD imm
    if (b[7:2] == 6'b100011) return 2;   // CMP imm
    if (b[7:5] == 3'b101)    return 2;   // BRA/BHI/BEQ
    return 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_branch(input logic [7:0] t);
    branch_valid  = 1'b1;
    branch_target = t;
    tick();
    branch_valid  = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (obs !== 27'd0) begin
      $display("FAIL reset_outputs: got %h required %h", obs, 27'd0); errors++;
    end
    checks++;
    if (address_bus !== 8'h00) begin
      $display("FAIL reset_addr: got %h required %h", address_bus, 8'h00); errors++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (instr_valid !== 1'b0) begin
      $display("FAIL reset_release_valid: got %b required 0", instr_valid); errors++;
    end
  endtask

  task automatic test_two_byte;
    rom[0] = 8'h81; rom[1] = 8'h00;
    fetch_en = 1'b1; instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'h01) begin
      $display("FAIL two_byte_imm_phase: got valid=%b addr=%h required valid=0 addr=01",
               instr_valid, address_bus); errors++;
    end
    tick();
    checks++;
    if (obs !== mk(8'h81, 8'h00, 2'd2, 8'h00)) begin
      $display("FAIL two_byte_instr: got %h required %h", obs, mk(8'h81, 8'h00, 2'd2, 8'h00)); errors++;
    end
    checks++;
    if (address_bus !== 8'h02) begin
      $display("FAIL two_byte_addr: got %h required 02", address_bus); errors++;
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      $display("FAIL two_byte_accept: got valid=%b required 0", instr_valid); errors++;
    end
  endtask

  task automatic test_one_byte;
    rom[4] = 8'h98; rom[5] = 8'h61;
    instr_ready = 1'b1;
    pulse_branch(8'h04);
    tick();
    checks++;
    if (obs !== mk(8'h98, 8'h00, 2'd1, 8'h04)) begin
      $display("FAIL one_byte_first: got %h required %h", obs, mk(8'h98, 8'h00, 2'd1, 8'h04)); errors++;
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      $display("FAIL one_byte_gap: got valid=%b required 0", instr_valid); errors++;
    end
    tick();
    checks++;
    if (obs !== mk(8'h61, 8'h00, 2'd1, 8'h05)) begin
      $display("FAIL one_byte_second: got %h required %h", obs, mk(8'h61, 8'h00, 2'd1, 8'h05)); errors++;
    end
  endtask

  task automatic test_backpressure;
    rom[11] = 8'hA8; rom[12] = 8'h04;
    instr_ready = 1'b0;
    pulse_branch(8'h0B);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== mk(8'hA8, 8'h04, 2'd2, 8'h0B) || address_bus !== 8'h0D) begin
        $display("FAIL backpressure_hold[%0d]: got %h addr=%h required %h addr=0d",
                 i, obs, address_bus, mk(8'hA8, 8'h04, 2'd2, 8'h0B)); errors++;
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'h0D) begin
      $display("FAIL backpressure_accept: got valid=%b addr=%h required valid=0 addr=0d",
               instr_valid, address_bus); errors++;
    end
  endtask

  task automatic test_redirect;
    rom[20] = 8'h81; rom[21] = 8'h55; rom[4] = 8'h98;
    instr_ready = 1'b1;
    pulse_branch(8'd20);
    tick();
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'd21) begin
      $display("FAIL redirect_in_imm_setup: got valid=%b addr=%h required valid=0 addr=15",
               instr_valid, address_bus); errors++;
    end
    pulse_branch(8'h04);
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'h04) begin
      $display("FAIL redirect_discard: got valid=%b addr=%h required valid=0 addr=04",
               instr_valid, address_bus); errors++;
    end
    tick();
    checks++;
    if (obs !== mk(8'h98, 8'h00, 2'd1, 8'h04)) begin
      $display("FAIL redirect_target_instr: got %h required %h", obs, mk(8'h98, 8'h00, 2'd1, 8'h04)); errors++;
    end
    // Accept and redirect in the same cycle.
    pulse_branch(8'h0B);
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'h0B) begin
      $display("FAIL accept_and_branch: got valid=%b addr=%h required valid=0 addr=0b",
               instr_valid, address_bus); errors++;
    end
    tick();
    tick();
    checks++;
    if (obs !== mk(8'hA8, 8'h04, 2'd2, 8'h0B)) begin
      $display("FAIL accept_and_branch_next: got %h required %h", obs, mk(8'hA8, 8'h04, 2'd2, 8'h0B)); errors++;
    end
  endtask

  task automatic test_wrap;
    rom[8'hFF] = 8'hB4; rom[0] = 8'h1A;
    instr_ready = 1'b0;
    pulse_branch(8'hFF);
    tick();
    tick();
    checks++;
    if (obs !== mk(8'hB4, 8'h1A, 2'd2, 8'hFF)) begin
      $display("FAIL wrap_instr: got %h required %h", obs, mk(8'hB4, 8'h1A, 2'd2, 8'hFF)); errors++;
    end
    checks++;
    if (address_bus !== 8'h01) begin
      $display("FAIL wrap_addr: got %h required 01", address_bus); errors++;
    end
  endtask

  task automatic test_fetch_en;
    rom[20] = 8'h81; rom[21] = 8'h55;
    instr_ready = 1'b0;
    pulse_branch(8'd20);
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0 || address_bus !== 8'd21) begin
        $display("FAIL fetch_en_freeze[%0d]: got valid=%b addr=%h required valid=0 addr=15",
                 i, instr_valid, address_bus); errors++;
      end
    end
    fetch_en = 1'b1;
    tick();
    checks++;
    if (obs !== mk(8'h81, 8'h55, 2'd2, 8'd20)) begin
      $display("FAIL fetch_en_resume: got %h required %h", obs, mk(8'h81, 8'h55, 2'd2, 8'd20)); errors++;
    end
    // Handshake completes with fetch_en low, then fetch stays frozen in S_OP.
    fetch_en = 1'b0; instr_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b0 || address_bus !== 8'd22) begin
      $display("FAIL fetch_en_handshake: got valid=%b addr=%h required valid=0 addr=16",
               instr_valid, address_bus); errors++;
    end
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_async;
    rom[0] = 8'h81; rom[1] = 8'h00;
    instr_ready = 1'b0;
    pulse_branch(8'd20);
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 27'd0 || address_bus !== 8'h00) begin
      $display("FAIL reset_mid_imm: got %h addr=%h required 0 addr=00", obs, address_bus); errors++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== mk(8'h81, 8'h00, 2'd2, 8'h00)) begin
      $display("FAIL reset_restart_1: got %h required %h", obs, mk(8'h81, 8'h00, 2'd2, 8'h00)); errors++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 27'd0 || address_bus !== 8'h00) begin
      $display("FAIL reset_in_valid: got %h addr=%h required 0 addr=00", obs, address_bus); errors++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== mk(8'h81, 8'h00, 2'd2, 8'h00)) begin
      $display("FAIL reset_restart_2: got %h required %h", obs, mk(8'h81, 8'h00, 2'd2, 8'h00)); errors++;
    end
  endtask

  task automatic test_random;
    logic [7:0]  exp_pc;
    logic [7:0]  e_op;
    logic [7:0]  e_opd;
    int          e_len;
    logic [26:0] e_vec;
    logic        br;
    int          accepts;
    accepts = 0;
    exp_pc  = 8'h00;
    for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      instr_ready = (i == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      fetch_en    = ($urandom_range(0, 3) != 0);
      br          = (i == 0) || ($urandom_range(0, 15) == 0);
      branch_valid  = br;
      branch_target = 8'($urandom);
      if (i > 0 && instr_valid && instr_ready) begin
        e_op   = rom[exp_pc];
        e_len  = ref_len(e_op);
        e_opd  = (e_len == 2) ? rom[8'(exp_pc + 8'd1)] : 8'h00;
        e_vec  = mk(e_op, e_opd, 2'(e_len), exp_pc);
        $display("txn %0d: pc=%h op=%h opd=%h len=%0d", accepts, instr_pc, instr_opcode,
                 instr_operand, instr_len);
        checks++;
        if (obs !== e_vec) begin
          $display("FAIL random_instr[%0d]: got %h required %h", accepts, obs, e_vec); errors++;
        end
        exp_pc = 8'(exp_pc + 8'(e_len));
        accepts++;
      end
      if (br) exp_pc = branch_target;
      tick();
    end
    branch_valid = 1'b0;
    checks++;
    if (accepts < 100) begin
      $display("FAIL random_progress: got %0d accepted required at least 100", accepts); errors++;
    end
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 8'h00;
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    test_reset();
    test_two_byte();
    test_one_byte();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_fetch_en();
    test_reset_async();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
